// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Captures retired-instruction commits from the core's write-back debug port,
// tags each with a 16-bit sequence number and queues it in a flop FIFO that a
// slower consumer drains over a valid/ready port. Commits that arrive while
// the FIFO is full are dropped; a sticky overflow flag and a saturating drop
// counter report them, and the skipped sequence numbers mark where they were.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb_have_inst, wb_pc,
//   wb_ena, wb_reg, wb_value    commit from the core
//   trace_en                    capture enable (commit_cnt counts regardless)
//   clr_ovf                     pulse: clear overflow / drop_cnt
//   tr_ready                    consumer accepts head entry
//   tr_valid, tr_seq, tr_pc,
//   tr_ena, tr_reg, tr_value    head entry (data zero while empty)
//   count                       occupancy
//   overflow, drop_cnt          drop reporting
//   commit_cnt                  every retired instruction, wrapping
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter bit FILTER_WB = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_have_inst,
  input  logic [31:0]                wb_pc,
  input  logic                       wb_ena,
  input  logic [4:0]                 wb_reg,
  input  logic [31:0]                wb_value,
  input  logic                       trace_en,
  input  logic                       clr_ovf,
  input  logic                       tr_ready,
  output logic                       tr_valid,
  output logic [15:0]                tr_seq,
  output logic [31:0]                tr_pc,
  output logic                       tr_ena,
  output logic [4:0]                 tr_reg,
  output logic [31:0]                tr_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic [31:0]                commit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] value;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   seq_q, seq_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic [31:0]   commit_q, commit_d;

  logic   qual, full, empty, push, pop, drop;
  entry_t head;
  entry_t wr_entry;

  assign qual  = wb_have_inst && trace_en &&
                 (!FILTER_WB || (wb_ena && (wb_reg != 5'd0)));
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && tr_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = qual && (!full || pop);
  assign drop  = qual && full && !pop;

  assign wr_entry = '{seq: seq_q, pc: wb_pc, ena: wb_ena, rg: wb_reg, value: wb_value};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    commit_d = commit_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Sequence advances on every qualified commit, stored or dropped.
    if (qual)         seq_d    = seq_q + 16'd1;
    if (wb_have_inst) commit_d = commit_q + 32'd1;

    // A drop coinciding with a clear wins: the clear takes effect first.
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_ovf ? 16'd1 : ((drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      commit_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      commit_q <= commit_d;
      if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Slot under rd_ptr may hold stale data once drained, so gate with valid.
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign tr_valid = !empty;
  assign tr_seq   = head.seq;
  assign tr_pc    = head.pc;
  assign tr_ena   = head.ena;
  assign tr_reg   = head.rg;
  assign tr_value = head.value;

  assign count      = count_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;
  assign commit_cnt = commit_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_have_inst = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_value = '0;
  logic        trace_en = 1'b1;
  logic        clr_ovf = 1'b0;
  logic        tr_ready = 1'b0;

  logic        tr_valid, tr_ena, overflow;
  logic [15:0] tr_seq, drop_cnt;
  logic [31:0] tr_pc, tr_value, commit_cnt;
  logic [4:0]  tr_reg, count;

  logic        f_valid, f_ena, f_overflow;
  logic [15:0] f_seq, f_drop;
  logic [31:0] f_pc, f_value, f_commit;
  logic [4:0]  f_reg, f_count;

  wb_trace_buffer #(.DEPTH(DEPTH), .FILTER_WB(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value), .trace_en(trace_en),
    .clr_ovf(clr_ovf), .tr_ready(tr_ready), .tr_valid(tr_valid), .tr_seq(tr_seq),
    .tr_pc(tr_pc), .tr_ena(tr_ena), .tr_reg(tr_reg), .tr_value(tr_value),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .commit_cnt(commit_cnt)
  );

  wb_trace_buffer #(.DEPTH(DEPTH), .FILTER_WB(1'b1)) u_flt (
    .clk(clk), .rst_n(rst_n), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
    .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value), .trace_en(trace_en),
    .clr_ovf(clr_ovf), .tr_ready(tr_ready), .tr_valid(f_valid), .tr_seq(f_seq),
    .tr_pc(f_pc), .tr_ena(f_ena), .tr_reg(f_reg), .tr_value(f_value),
    .count(f_count), .overflow(f_overflow), .drop_cnt(f_drop), .commit_cnt(f_commit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Expected drain order for u_dut: {seq, pc, ena, reg, value}
  logic [85:0] exp_q [$];

  // Reference model state for u_dut (FILTER_WB=0)
  int          m_count = 0;
  logic [15:0] m_seq = '0;
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_commit = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted head entry is compared with the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && tr_valid && tr_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL drain_unexpected: got seq 0x%0h, expected no entry", tr_seq);
      end else begin
        if ({tr_seq, tr_pc, tr_ena, tr_reg, tr_value} === exp_q[0]) n_pass++;
        else $display("FAIL drain_entry: got 0x%0h, expected 0x%0h",
                      {tr_seq, tr_pc, tr_ena, tr_reg, tr_value}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; updates the model and pushes expectations.
  task automatic cyc(input logic have, input logic en, input logic ena,
                     input logic [4:0] rg, input logic [31:0] pc, input logic [31:0] val,
                     input logic rdy, input logic clr);
    logic pop, q;
    wb_have_inst = have; trace_en = en; wb_ena = ena; wb_reg = rg;
    wb_pc = pc; wb_value = val; tr_ready = rdy; clr_ovf = clr;
    pop = rdy && (m_count > 0);
    q   = have && en;
    if (have) m_commit++;
    if (clr) begin m_ovf = 1'b0; m_drop = '0; end
    if (q) begin
      if (m_count < DEPTH || pop) begin
        exp_q.push_back({m_seq, pc, ena, rg, val});
        m_count++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
      m_seq++;
    end
    if (pop) m_count--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_have_inst = 1'b0; tr_ready = 1'b0; clr_ovf = 1'b0; trace_en = 1'b1;
    #3;
    m_count = 0; m_seq = '0; m_drop = '0; m_ovf = 1'b0; m_commit = '0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"},    64'(count),      64'(m_count));
    chk({tag, "_overflow"}, 64'(overflow),   64'(m_ovf));
    chk({tag, "_drop"},     64'(drop_cnt),   64'(m_drop));
    chk({tag, "_commit"},   64'(commit_cnt), 64'(m_commit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    // Reset state
    chk("rst_valid", 64'(tr_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data", {tr_seq, tr_pc[15:0], tr_value[15:0], tr_reg, tr_ena}, 64'd0);
    chk("rst_commit", 64'(commit_cnt), 64'd0);

    // Single commit, one-cycle latency
    cyc(1'b1, 1'b1, 1'b1, 5'd5, 32'h4, 32'h1234, 1'b0, 1'b0);
    chk("single_valid", 64'(tr_valid), 64'd1);
    chk("single_seq", 64'(tr_seq), 64'd0);
    chk("single_pc", 64'(tr_pc), 64'h4);
    chk("single_reg", 64'(tr_reg), 64'd5);
    chk("single_value", 64'(tr_value), 64'h1234);
    chk("single_count", 64'(count), 64'd1);
    idle(1'b1);
    chk("single_drained_valid", 64'(tr_valid), 64'd0);
    chk("single_drained_count", 64'(count), 64'd0);

    // 20 commits into a blocked FIFO: 16 stored, 4 dropped
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, 1'b1, 5'(i + 1), 32'(i * 4), 32'(32'hA000 + i), 1'b0, 1'b0);
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drop", 64'(drop_cnt), 64'd4);
    chk("fill_head_stable", 64'(tr_seq), 64'd0);
    // Full with simultaneous pop and push: new entry carries seq 20
    cyc(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_AAAA, 32'h5555, 1'b1, 1'b0);
    chk("fullpp_count", 64'(count), 64'd16);
    chk("fullpp_drop", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("fullpp_last_seq", 64'(tr_seq), 64'd20);
    chk("fullpp_last_pc", 64'(tr_pc), 64'h0000_AAAA);
    idle(1'b1);
    chk_model("fill_end");
    chk("fill_sb_empty", 64'(exp_q.size()), 64'd0);

    // FILTER_WB=1 instance: only the reg=7 write is recorded
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 5'd3, 32'h100, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 5'd0, 32'h104, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 5'd7, 32'h108, 32'h33, 1'b0, 1'b0);
    chk("flt_count", 64'(f_count), 64'd1);
    chk("flt_seq", 64'(f_seq), 64'd0);
    chk("flt_reg", 64'(f_reg), 64'd7);
    chk("flt_value", 64'(f_value), 64'h33);
    chk("flt_commit", 64'(f_commit), 64'd3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("flt_drained", 64'(f_count), 64'd0);

    // trace_en gating
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 1'b1, 5'd1, 32'(i), 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 32'h200, 32'h77, 1'b0, 1'b0);
    chk("ten_commit", 64'(commit_cnt), 64'd6);
    chk("ten_count", 64'(count), 64'd1);
    chk("ten_seq", 64'(tr_seq), 64'd0);
    idle(1'b1);

    // clr_ovf alone, then coincident with a drop
    do_reset();
    for (int i = 0; i < 18; i++)
      cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'(i), 32'(i), 1'b0, 1'b0);
    chk("clr_pre_drop", 64'(drop_cnt), 64'd2);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'h300, 32'h1, 1'b0, 1'b1);
    chk("clr_vs_drop_ovf", 64'(overflow), 64'd1);
    chk("clr_vs_drop_cnt", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 16; i++) idle(1'b1);

    // Sequence wrap and drop_cnt saturation
    do_reset();
    for (int i = 0; i < 65536; i++)
      cyc(1'b1, 1'b1, 1'b1, 5'd6, 32'(i), 32'(i), 1'b0, 1'b0);
    chk("sat_pre_drop", 64'(drop_cnt), 64'd65520);
    cyc(1'b1, 1'b1, 1'b1, 5'd6, 32'hCAFE_0000, 32'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b1, 1'b1, 5'd6, 32'(i), 32'(i), 1'b0, 1'b0);
    chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
    chk("sat_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("wrap_seq", 64'(tr_seq), 64'h0000);
    chk("wrap_pc", 64'(tr_pc), 64'hCAFE_0000);
    idle(1'b1);
    chk_model("sat_end");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 5'd8, 32'(i), 32'(i), 1'b0, 1'b0);
    chk("mid_pre_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(tr_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 5'd9, 32'h400, 32'h99, 1'b0, 1'b0);
    chk("post_rst_seq", 64'(tr_seq), 64'd0);
    chk("post_rst_pc", 64'(tr_pc), 64'h400);
    idle(1'b1);
    idle(1'b0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace capture buffer that sits directly downstream of the single-cycle core's write-back debug outputs. Every cycle the core retires an instruction, the block tags the commit (PC, register-write enable, destination register, write value) with a sequence number and pushes it into a flop-based FIFO. A valid/ready drain port lets a slower consumer (UART dumper, golden-model comparator) read the trace in order. Sticky overflow and a drop counter report any commits lost while the FIFO was full.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- FILTER_WB, 0, 1 = record only commits with wb_ena=1 and wb_reg!=0; 0 = record every commit
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_have_inst  in  1  core retired an instruction this cycle
- wb_pc  in  32  PC of retired instruction
- wb_ena  in  1  register-file write enable of that instruction
- wb_reg  in  5  destination register
- wb_value  in  32  value written
- trace_en  in  1  capture enable; 0 = ignore commits (commit_cnt still counts)
- clr_ovf  in  1  one-cycle pulse, clears overflow and drop_cnt
- tr_ready  in  1  consumer accepts head entry
- tr_valid  out  1  FIFO non-empty, head entry presented
- tr_seq  out  16  sequence number of head entry
- tr_pc  out  32  head entry PC
- tr_ena  out  1  head entry write enable
- tr_reg  out  5  head entry destination register
- tr_value  out  32  head entry write value
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky, set on any dropped commit
- drop_cnt  out  16  dropped commits, saturating
- commit_cnt  out  32  all retired instructions, wrapping

## Operation
- Qualified commit: wb_have_inst=1 && trace_en=1 && (FILTER_WB=0 || (wb_ena=1 && wb_reg!=0)).
- Each qualified commit is assigned the current seq value; seq then increments by 1 (16-bit, wraps 0xFFFF->0x0000), whether the commit is stored or dropped. Gaps in tr_seq therefore mark drops.
- Push: qualified commit && (count<DEPTH || pop this cycle). Entry {seq, pc, ena, reg, value} written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: tr_valid && tr_ready. rd_ptr advances modulo DEPTH.
- Drop: qualified commit && count==DEPTH && no pop. Entry discarded, overflow<=1, drop_cnt+1 saturating at 0xFFFF.
- Full with simultaneous pop and push: both occur, count stays DEPTH, no drop.
- Empty: tr_valid=0, pop impossible; no same-cycle bypass of a pushed entry.
- count: +1 on push-only, -1 on pop-only, unchanged on both/neither.
- clr_ovf: overflow<=0, drop_cnt<=0; a drop in the same cycle wins, giving overflow=1, drop_cnt=1.
- commit_cnt increments on every wb_have_inst=1 regardless of trace_en, filter or full state.
- Head payload stable while tr_valid=1 && tr_ready=0.

## Timing
- Reset (rst_n low, asynchronous): pointers, count, seq, overflow, drop_cnt, commit_cnt, all storage = 0; tr_valid=0; all tr_* data outputs 0.
- Push-to-visible latency: 1 cycle; a commit sampled at edge N appears at tr_* after edge N, so tr_valid=1 in cycle N+1 if FIFO was empty.
- Pop takes effect at the edge where tr_valid && tr_ready; next entry (if any) presented in the following cycle, so sustained throughput is 1 entry/cycle.
- count, overflow, drop_cnt, commit_cnt are registered, updated on the same edge as the event.
- Reset asserted mid-stream: all contents discarded immediately; first commit after release gets seq 0.

## Test plan
- Reset then single commit pc=0x0000_0004, reg=5, value=0x1234, ena=1 -> next cycle tr_valid=1, tr_seq=0, tr_pc=0x4, tr_reg=5, tr_value=0x1234, count=1; tr_ready=1 -> tr_valid=0, count=0.
- DEPTH=16, tr_ready=0, 20 consecutive commits -> count=16, overflow=1, drop_cnt=4; drain shows seq 0..15 in order; 21st commit carries seq 20.
- Full FIFO, tr_ready=1 and commit same cycle -> count stays 16, drop_cnt unchanged, new entry appears last in drain order.
- FILTER_WB=1: commits (ena=0,reg=3), (ena=1,reg=0), (ena=1,reg=7) -> only reg=7 stored, tr_seq=0; commit_cnt=3.
- trace_en=0 for 5 commits then 1 for 1 commit -> commit_cnt=6, one entry, tr_seq=0; clr_ovf coincident with drop -> overflow=1, drop_cnt=1.
- 65537 qualified commits with tr_ready=1 -> final entry tr_seq=0x0000; drop_cnt forced past 0xFFFF stays 0xFFFF; rst_n pulsed mid-stream -> tr_valid=0, count=0 asynchronously.
